// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
//   Shared definitions for the single-clock FIFO family (sync_fifo_wl).
//   - fifo_mode_e : read-mode selector values for the FWFT_MODE parameter
//   - clog2       : ceiling log2, used to size RAM addresses
//   - fifo_params_ok : threshold range check evaluated at elaboration
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  // Read-mode encodings accepted by FWFT_MODE.
  typedef enum int unsigned {
    FIFO_STD  = 0,
    FIFO_FWFT = 1
  } fifo_mode_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v != 0) begin
        res = res + 1;
        v   = v >> 1;
      end
    end
    return res;
  endfunction

  // Thresholds must fit the depth: ALMOST_FULL_NUM in 1..DEPTH,
  // ALMOST_EMPTY_NUM in 0..DEPTH-1.
  function automatic bit fifo_params_ok(input int unsigned depth_width,
                                        input int unsigned almost_full_num,
                                        input int unsigned almost_empty_num);
    int unsigned depth;
    depth = 32'd1 << depth_width;
    return (almost_full_num >= 1) && (almost_full_num <= depth) &&
           (almost_empty_num < depth);
  endfunction

endpackage

// File: rtl/sfifo_dpram.sv
// -----------------------------------------------------------------------------
// sfifo_dpram
//   Simple dual-port RAM for the FIFO storage: one write port, one read port,
//   registered read data. Written to map onto block RAM.
//   Ports:
//     clk   - clock
//     rst   - synchronous active-high reset of the read-data register only
//     we    - write enable
//     waddr - write address
//     wdata - write data
//     re    - read enable; rdata updates on the next edge, otherwise holds
//     raddr - read address
//     rdata - registered read data
// -----------------------------------------------------------------------------
module sfifo_dpram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned DEPTH      = 4096,
  localparam int unsigned AW        = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Output-register reset maps onto the block RAM output-latch reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_wl.sv
// -----------------------------------------------------------------------------
// sync_fifo_wl
//   Single-clock FIFO with standard or first-word-fall-through read mode,
//   programmable almost-full / almost-empty thresholds and an exact water level.
//   Optional sticky error flags are built when SYNC_FIFO_ERR_STAT_EN is defined.
//   Ports:
//     clk          - clock, all logic on posedge
//     rst          - synchronous reset, active-high
//     wr_data      - write word
//     wr_en        - write request (dropped while wr_full)
//     wr_full      - FIFO holds DEPTH words
//     almost_full  - water_level >= ALMOST_FULL_NUM
//     rd_en        - standard: read request; FWFT: pop of presented word
//     rd_data      - read word
//     rd_empty     - no readable word
//     almost_empty - water_level <= ALMOST_EMPTY_NUM
//     water_level  - words written and not yet popped (0..DEPTH)
//     overflow     - (SYNC_FIFO_ERR_STAT_EN) sticky, wr_en while wr_full
//     underflow    - (SYNC_FIFO_ERR_STAT_EN) sticky, rd_en while rd_empty
// -----------------------------------------------------------------------------
module sync_fifo_wl
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 24,
  parameter int unsigned DEPTH_WIDTH      = 12,
  parameter int unsigned FWFT_MODE        = 0,
  parameter int unsigned ALMOST_FULL_NUM  = 4090,
  parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  wr_full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty,
  output logic                  almost_empty,
  output logic [DEPTH_WIDTH:0]  water_level
`ifdef SYNC_FIFO_ERR_STAT_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int unsigned DEPTH = 32'd1 << DEPTH_WIDTH;
  localparam bit          FWFT  = (FWFT_MODE == FIFO_FWFT);

  typedef logic [DEPTH_WIDTH:0]   cnt_t;
  typedef logic [DATA_WIDTH-1:0]  word_t;

  if (!fifo_params_ok(DEPTH_WIDTH, ALMOST_FULL_NUM, ALMOST_EMPTY_NUM)) begin : g_param_err
    $error("sync_fifo_wl: need 1 <= ALMOST_FULL_NUM <= DEPTH and ALMOST_EMPTY_NUM < DEPTH");
  end

  cnt_t  wr_ptr_q, wr_ptr_d;
  cnt_t  rd_ptr_q, rd_ptr_d;
  cnt_t  level_q, level_d;
  logic  wr_full_q, wr_full_d;
  logic  almost_full_q, almost_full_d;
  logic  almost_empty_q, almost_empty_d;
  logic  rd_empty_q, rd_empty_d;
  logic  s1_valid_q, s1_valid_d;
  word_t rd_data_q, rd_data_d;

  logic  wr_acc;
  logic  rd_acc;
  logic  ram_re;
  logic  out_load;
  word_t ram_rdata;

  // In FWFT mode rd_ptr is the RAM fetch pointer, not the pop pointer: it runs
  // ahead of the consumer by the words held in the RAM read register (s1) and
  // the output register. rd_empty tracks the output register's validity.
  always_comb begin
    wr_acc = wr_en & ~wr_full_q;
    rd_acc = rd_en & ~rd_empty_q;

    wr_ptr_d = wr_ptr_q + cnt_t'(wr_acc);

    level_d = level_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + cnt_t'(1);
      2'b01:   level_d = level_q - cnt_t'(1);
      default: level_d = level_q;
    endcase

    out_load   = 1'b0;
    s1_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_ptr_d   = rd_ptr_q;
    ram_re     = 1'b0;
    rd_empty_d = (level_d == '0);

    if (FWFT) begin
      // Output register refills from s1 when it is empty or being popped.
      out_load   = s1_valid_q & (rd_empty_q | rd_acc);
      // Fetch only when RAM holds unfetched words, so the read address never
      // equals the write address of the same cycle.
      ram_re     = (wr_ptr_q != rd_ptr_q) & (~s1_valid_q | out_load);
      s1_valid_d = ram_re | (s1_valid_q & ~out_load);
      rd_ptr_d   = rd_ptr_q + cnt_t'(ram_re);
      rd_empty_d = ~(out_load | (~rd_empty_q & ~rd_acc));
      if (out_load) begin
        rd_data_d = ram_rdata;
      end
    end else begin
      ram_re   = rd_acc;
      rd_ptr_d = rd_ptr_q + cnt_t'(rd_acc);
    end

    wr_full_d      = (level_d == cnt_t'(DEPTH));
    almost_full_d  = (level_d >= cnt_t'(ALMOST_FULL_NUM));
    almost_empty_d = (level_d <= cnt_t'(ALMOST_EMPTY_NUM));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      wr_full_q      <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      rd_empty_q     <= 1'b1;
      s1_valid_q     <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      wr_full_q      <= wr_full_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      rd_empty_q     <= rd_empty_d;
      s1_valid_q     <= s1_valid_d;
      rd_data_q      <= rd_data_d;
    end
  end

  sfifo_dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr_q[DEPTH_WIDTH-1:0]),
    .wdata (wr_data),
    .re    (ram_re & ~rst),
    .raddr (rd_ptr_q[DEPTH_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  assign wr_full      = wr_full_q;
  assign almost_full  = almost_full_q;
  assign rd_empty     = rd_empty_q;
  assign almost_empty = almost_empty_q;
  assign water_level  = level_q;
  assign rd_data      = FWFT ? rd_data_q : ram_rdata;

`ifdef SYNC_FIFO_ERR_STAT_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (wr_en & wr_full_q);
    underflow_d = underflow_q | (rd_en & rd_empty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_wl.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_wl
//   Drives one standard-mode and one FWFT-mode sync_fifo_wl (24 bit, depth 16,
//   AF=14, AE=2) with the same stimulus and checks both against queue/timestamp
//   reference models every cycle, plus literal expectations for key moments.
// -----------------------------------------------------------------------------
module tb_sync_fifo_wl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [23:0] wr_data;

  logic        s_full, s_af, s_empty, s_ae;
  logic [23:0] s_rd;
  logic [4:0]  s_lvl;
  logic        f_full, f_af, f_empty, f_ae;
  logic [23:0] f_rd;
  logic [4:0]  f_lvl;
`ifdef SYNC_FIFO_ERR_STAT_EN
  logic        s_ovf, s_unf, f_ovf, f_unf;
`endif

  always #5 clk = ~clk;

  sync_fifo_wl #(
    .DATA_WIDTH(24), .DEPTH_WIDTH(4), .FWFT_MODE(0),
    .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)
  ) u_std (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
    .wr_full(s_full), .almost_full(s_af), .rd_en(rd_en), .rd_data(s_rd),
    .rd_empty(s_empty), .almost_empty(s_ae), .water_level(s_lvl)
`ifdef SYNC_FIFO_ERR_STAT_EN
    , .overflow(s_ovf), .underflow(s_unf)
`endif
  );

  sync_fifo_wl #(
    .DATA_WIDTH(24), .DEPTH_WIDTH(4), .FWFT_MODE(1),
    .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)
  ) u_fwft (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
    .wr_full(f_full), .almost_full(f_af), .rd_en(rd_en), .rd_data(f_rd),
    .rd_empty(f_empty), .almost_empty(f_ae), .water_level(f_lvl)
`ifdef SYNC_FIFO_ERR_STAT_EN
    , .overflow(f_ovf), .underflow(f_unf)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference models ----------------
  int e_cnt = 0;  // index of the next clock edge

  // Standard mode: a plain queue of stored words.
  logic [23:0] qs[$];
  int          lvl_s;
  logic [23:0] rd_s;
  bit          ovf_s, unf_s;

  // FWFT mode: per-word write edge; the head's presentation edge follows from
  // timing rules: fetch edge F = max(w+1, P(prev)), presentation
  // P = max(F+1, pop edge of prev).
  logic [23:0] wd_f[$];
  int          we_f[$];
  int          nwr_f, npop_f, p_last, q_last, lvl_f;
  bit          ovf_f, unf_f;

  function automatic int head_present_edge();
    int f;
    int p;
    f = we_f[npop_f] + 1;
    if (p_last > f) f = p_last;
    p = f + 1;
    if (q_last > p) p = q_last;
    return p;
  endfunction

  function automatic bit fwft_empty_after(input int t);
    if (npop_f >= nwr_f) return 1'b1;
    return head_present_edge() > t;
  endfunction

  task automatic model_edge(input bit r, input bit w, input bit rd, input logic [23:0] d);
    bit wa, ra, emp_pre;
    if (r) begin
      qs.delete(); lvl_s = 0; rd_s = '0; ovf_s = 0; unf_s = 0;
      wd_f.delete(); we_f.delete();
      nwr_f = 0; npop_f = 0; p_last = -1000; q_last = -1000; lvl_f = 0;
      ovf_f = 0; unf_f = 0;
    end else begin
      wa = w && (lvl_s != 16);
      ra = rd && (lvl_s != 0);
      if (w && lvl_s == 16) ovf_s = 1;
      if (rd && lvl_s == 0) unf_s = 1;
      if (ra) rd_s = qs.pop_front();
      if (wa) qs.push_back(d);
      lvl_s = lvl_s + int'(wa) - int'(ra);

      emp_pre = fwft_empty_after(e_cnt - 1);
      wa = w && (lvl_f != 16);
      ra = rd && !emp_pre;
      if (w && lvl_f == 16) ovf_f = 1;
      if (rd && emp_pre) unf_f = 1;
      if (ra) begin
        p_last = head_present_edge();
        q_last = e_cnt;
        npop_f++;
      end
      if (wa) begin
        wd_f.push_back(d);
        we_f.push_back(e_cnt);
        nwr_f++;
      end
      lvl_f = lvl_f + int'(wa) - int'(ra);
    end
    e_cnt++;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("std_level",    32'(s_lvl),   32'(lvl_s));
      chk("std_full",     32'(s_full),  32'(lvl_s == 16));
      chk("std_afull",    32'(s_af),    32'(lvl_s >= 14));
      chk("std_aempty",   32'(s_ae),    32'(lvl_s <= 2));
      chk("std_empty",    32'(s_empty), 32'(lvl_s == 0));
      chk("std_rd_data",  32'(s_rd),    32'(rd_s));
      chk("fwft_level",   32'(f_lvl),   32'(lvl_f));
      chk("fwft_full",    32'(f_full),  32'(lvl_f == 16));
      chk("fwft_afull",   32'(f_af),    32'(lvl_f >= 14));
      chk("fwft_aempty",  32'(f_ae),    32'(lvl_f <= 2));
      chk("fwft_empty",   32'(f_empty), 32'(fwft_empty_after(e_cnt - 1)));
      if (!fwft_empty_after(e_cnt - 1)) begin
        chk("fwft_rd_data", 32'(f_rd), 32'(wd_f[npop_f]));
      end
`ifdef SYNC_FIFO_ERR_STAT_EN
      chk("std_overflow",   32'(s_ovf), 32'(ovf_s));
      chk("std_underflow",  32'(s_unf), 32'(unf_s));
      chk("fwft_overflow",  32'(f_ovf), 32'(ovf_f));
      chk("fwft_underflow", 32'(f_unf), 32'(unf_f));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle(input bit r, input bit w, input bit rd, input logic [23:0] d);
    rst = r; wr_en = w; rd_en = rd; wr_data = d;
    @(posedge clk);
    model_edge(r, w, rd, d);
    #1;
  endtask

  initial begin
    int pw;
    logic [23:0] v;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

    cycle(1, 0, 0, '0);
    chk_on = 1'b1;
    cycle(1, 0, 0, '0);
    chk("rst_std_level", 32'(s_lvl), 32'd0);
    chk("rst_std_empty", 32'(s_empty), 32'd1);
    chk("rst_std_aempty", 32'(s_ae), 32'd1);
    chk("rst_fwft_rd_data", 32'(f_rd), 32'd0);

    // Fill with 0xFFFFFF down to 0xFFFFF0, then one dropped write.
    for (int i = 1; i <= 16; i++) begin
      v = 24'hFFFFFF - 24'(i - 1);
      cycle(0, 1, 0, v);
      chk("fill_std_afull", 32'(s_af), 32'(i >= 14));
    end
    chk("fill_std_full", 32'(s_full), 32'd1);
    chk("fill_std_level", 32'(s_lvl), 32'd16);
    cycle(0, 1, 0, 24'hABCDEF);
    chk("over_std_level", 32'(s_lvl), 32'd16);

    // Drain with one extra read.
    for (int i = 1; i <= 17; i++) begin
      cycle(0, 0, 1, '0);
      if (i == 1) chk("drain_std_first", 32'(s_rd), 32'hFFFFFF);
    end
    chk("drain_std_empty", 32'(s_empty), 32'd1);

    // Simultaneous requests at full and at empty.
    for (int i = 0; i < 16; i++) cycle(0, 1, 0, 24'h100 + 24'(i));
    cycle(0, 1, 1, 24'hDEAD00);
    chk("both_full_std_level", 32'(s_lvl), 32'd15);
    for (int i = 0; i < 18; i++) cycle(0, 0, 1, '0);
    cycle(0, 1, 1, 24'hBEEF00);
    chk("both_empty_std_level", 32'(s_lvl), 32'd1);

    // FWFT latency and back-to-back pops.
    cycle(1, 0, 0, '0);
    cycle(0, 1, 0, 24'h123456);
    chk("fwft_lat_n0", 32'(f_empty), 32'd1);
    cycle(0, 0, 0, '0);
    chk("fwft_lat_n1", 32'(f_empty), 32'd1);
    cycle(0, 0, 0, '0);
    chk("fwft_lat_n2_empty", 32'(f_empty), 32'd0);
    chk("fwft_lat_n2_data", 32'(f_rd), 32'h123456);
    cycle(0, 0, 1, '0);
    chk("fwft_pop_n3", 32'(f_empty), 32'd1);
    for (int i = 0; i < 9; i++) cycle(0, 1, 0, 24'h000A00 + 24'(i));
    repeat (3) cycle(0, 0, 0, '0);
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 1, '0);
      chk("fwft_b2b_empty", 32'(f_empty), 32'd0);
      chk("fwft_b2b_data", 32'(f_rd), 32'h000A00 + 32'(i));
    end

    // Reset mid-stream at level 9.
    cycle(1, 0, 0, '0);
    for (int i = 0; i < 9; i++) cycle(0, 1, 0, 24'h777000 + 24'(i));
    chk("pre_rst_std_level", 32'(s_lvl), 32'd9);
    cycle(1, 1, 1, 24'h999999);
    chk("mid_rst_std_level", 32'(s_lvl), 32'd0);
    chk("mid_rst_std_empty", 32'(s_empty), 32'd1);
    chk("mid_rst_std_rd", 32'(s_rd), 32'd0);
    chk("mid_rst_fwft_rd", 32'(f_rd), 32'd0);
    cycle(0, 1, 0, 24'h55AA55);
    cycle(0, 0, 1, '0);
    chk("post_rst_std_rd", 32'(s_rd), 32'h55AA55);

    // Randomised phases with varying write bias to sweep levels 0..16.
    for (int ph = 0; ph < 7; ph++) begin
      case (ph)
        0: pw = 85; 1: pw = 50; 2: pw = 15; 3: pw = 70;
        4: pw = 30; 5: pw = 95; default: pw = 5;
      endcase
      for (int i = 0; i < 200; i++) begin
        cycle(($urandom_range(0, 399) == 0),
              ($urandom_range(0, 99) < pw),
              ($urandom_range(0, 99) < (100 - pw)),
              24'($urandom));
      end
    end
    repeat (4) cycle(0, 0, 1, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
